mult_controller: RTL and testbench



---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_step_counter.sv | 38 +++
 rtl/mult_controller.sv | 110 +++++++++++
 tb/tb_mult_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the shift-and-add multiplier controller
//
// Purpose: FSM state encoding and the default operand width used by
// mult_controller and mult_step_counter.
// Ports: none (package).

package mult_pkg;

  // Default multiplier operand width; also the number of shift steps.
  localparam int MULT_N = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_step_counter.sv
// rtl/mult_step_counter.sv - step counter tracking shifts within one multiplication
//
// Purpose: $clog2(N)-bit counter of completed shift steps; flags the final step.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears the count)
//   clear      synchronous clear back to step 0
//   increment  advance to the next step
//   last       high while the count is on step N-1

module mult_step_counter
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic increment,
  output logic last
);

  localparam int W = $clog2(N);
  localparam logic [W-1:0] LAST_STEP = W'(N - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (increment) begin
      cnt <= cnt + W'(1);
    end
  end

  assign last = (cnt == LAST_STEP);

endmodule

// File: rtl/mult_controller.sv
// rtl/mult_controller.sv - control FSM for an N-bit sequential shift-and-add multiplier
//
// Purpose: walks the multiplier bits LSB first, issuing one-cycle add and
// shift strobes to the datapath, then a one-cycle done pulse.
// Ports:
//   clk_in  rising-edge clock
//   rst_in  synchronous active-high reset; also forces all outputs low
//   adx     start request, only looked at in IDLE
//   m       current LSB of the datapath multiplier register
//   sh      shift product/multiplier registers right this cycle
//   add     add multiplicand into the upper product half this cycle
//   done    one-cycle completion pulse

module mult_controller
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic adx,
  input  logic m,
  output logic sh,
  output logic add,
  output logic done
);

  state_t state;
  state_t state_next;
  logic   cnt_clear;
  logic   cnt_inc;
  logic   cnt_last;

  mult_step_counter #(
    .N(N)
  ) u_step_counter (
    .clk       (clk_in),
    .rst       (rst_in),
    .clear     (cnt_clear),
    .increment (cnt_inc),
    .last      (cnt_last)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    sh         = 1'b0;
    add        = 1'b0;
    done       = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;

    // Reset gates the strobes so a reset mid-operation never leaks a
    // partial add/shift or a done into the datapath.
    if (!rst_in) begin
      case (state)
        IDLE: begin
          if (adx) begin
            state_next = EVAL;
            cnt_clear  = 1'b1;
          end
        end

        EVAL: begin
          if (m) begin
            add        = 1'b1;
            state_next = SHIFT;
          end else begin
            // Zero bit: skip straight to the shift; stay in EVAL so the
            // next bit can be examined without an extra cycle.
            sh = 1'b1;
            if (cnt_last) begin
              state_next = DONE;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end

        SHIFT: begin
          sh = 1'b1;
          if (cnt_last) begin
            state_next = DONE;
          end else begin
            cnt_inc    = 1'b1;
            state_next = EVAL;
          end
        end

        DONE: begin
          done       = 1'b1;
          cnt_clear  = 1'b1;
          state_next = IDLE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_controller.sv
// tb/tb_mult_controller.sv - self-checking bench for mult_controller

module tb_mult_controller;
  import mult_pkg::*;

  localparam int N = MULT_N;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic adx    = 1'b0;
  logic m;
  logic sh;
  logic add;
  logic done;

  mult_controller #(.N(N)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .adx    (adx),
    .m      (m),
    .sh     (sh),
    .add    (add),
    .done   (done)
  );

  always #5 clk_in = ~clk_in;

  // Datapath model: {acc[N:0], mreg[N-1:0]}; m is the multiplier LSB.
  logic [2*N:0]   p        = '0;
  logic           load     = 1'b0;
  logic [N-1:0]   ld_mult  = '0;
  logic [N-1:0]   ld_mcand = '0;

  assign m = p[0];

  always @(posedge clk_in) begin
    if (load || done)
      p <= {{(N+1){1'b0}}, ld_mult};
    else if (add)
      p[2*N:N] <= p[2*N:N] + {1'b0, ld_mcand};
    else if (sh)
      p <= p >> 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Expected per-cycle events: 0 none, 1 add, 2 sh, 3 done, 4 illegal overlap.
  int exp_q[$];

  task automatic push_op(input logic [N-1:0] mult);
    for (int i = 0; i < N; i++) begin
      if (mult[i]) exp_q.push_back(1);
      exp_q.push_back(2);
    end
    exp_q.push_back(3);
  endtask

  int             o_adds, o_shs, o_active, o_dones;
  logic [2*N-1:0] o_prod;
  bit             o_seq_ok;

  task automatic check_seq(input string name);
    int ev;
    o_adds = 0; o_shs = 0; o_active = 0; o_dones = 0; o_prod = '0; o_seq_ok = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk_in);
      ev = 0;
      if (int'(sh) + int'(add) + int'(done) > 1) ev = 4;
      else if (add)  ev = 1;
      else if (sh)   ev = 2;
      else if (done) ev = 3;
      if (ev == 1) o_adds++;
      if (ev == 2) o_shs++;
      if (ev == 1 || ev == 2) o_active++;
      if (ev == 3) begin
        o_dones++;
        o_prod = p[2*N-1:0];
      end
      if (ev != exp_q[i] && o_seq_ok) begin
        o_seq_ok = 1'b0;
        $display("%s: cycle %0d event %0d, model wants %0d", name, i, ev, exp_q[i]);
      end
    end
    exp_q.delete();
    check({name, " sequence"}, longint'(o_seq_ok), 1);
  endtask

  task automatic start(input logic [N-1:0] mult, input logic [N-1:0] mcand, input logic hold);
    @(negedge clk_in);
    ld_mult  = mult;
    ld_mcand = mcand;
    load     = 1'b1;
    adx      = 1'b1;
    @(posedge clk_in);
    #1;
    load = 1'b0;
    adx  = hold;
  endtask

  typedef struct {
    logic [N-1:0] mult;
    logic [N-1:0] mcand;
    int           adds;
    int           shs;
    int           active;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b1011, 4'd5,  3, 4, 7};
    vecs[1] = '{4'b0000, 4'd9,  0, 4, 4};
    vecs[2] = '{4'b1111, 4'd15, 4, 4, 8};
    vecs[3] = '{4'b0101, 4'd3,  2, 4, 6};
    vecs[4] = '{4'b1000, 4'd7,  1, 4, 5};

    // Reset held with a pending start request.
    rst_in = 1'b1;
    adx    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in);
      check("reset outputs", {sh, add, done}, 0);
      check("reset state", dut.state, IDLE);
    end
    rst_in = 1'b0;
    adx    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      check("idle outputs", {sh, add, done}, 0);
    end

    // Table of fixed multipliers.
    for (int v = 0; v < 5; v++) begin
      push_op(vecs[v].mult);
      start(vecs[v].mult, vecs[v].mcand, 1'b0);
      check_seq($sformatf("vec%0d", v));
      check($sformatf("vec%0d adds", v), o_adds, vecs[v].adds);
      check($sformatf("vec%0d shifts", v), o_shs, vecs[v].shs);
      check($sformatf("vec%0d active", v), o_active, vecs[v].active);
      check($sformatf("vec%0d product", v), o_prod, vecs[v].mult * vecs[v].mcand);
      @(negedge clk_in);
      check($sformatf("vec%0d done after", v), done, 0);
    end

    // adx held high: back-to-back operations separated by one IDLE cycle.
    push_op(4'b0101);
    exp_q.push_back(0);
    push_op(4'b0101);
    start(4'b0101, 4'd11, 1'b1);
    check_seq("continuous");
    adx = 1'b0;
    check("continuous adds", o_adds, 4);
    check("continuous shifts", o_shs, 8);
    check("continuous dones", o_dones, 2);
    check("continuous product", o_prod, 5 * 11);

    // Reset after the second shift of 1011: no done, back to IDLE.
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(1);
    exp_q.push_back(2);
    start(4'b1011, 4'd6, 1'b0);
    check_seq("abort prefix");
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(negedge clk_in);
    check("abort outputs in reset", {sh, add, done}, 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    check("abort state", dut.state, IDLE);
    for (int i = 0; i < 8; i++) begin
      check("abort quiet", {sh, add, done}, 0);
      @(negedge clk_in);
    end
    push_op(4'b1011);
    start(4'b1011, 4'd6, 1'b0);
    check_seq("after abort");
    check("after abort product", o_prod, 11 * 6);

    // Randomised operations against the arithmetic model.
    for (int r = 0; r < 24; r++) begin
      logic [N-1:0] rm;
      logic [N-1:0] rc;
      int           pop;
      rm  = N'($urandom_range(0, (1 << N) - 1));
      rc  = N'($urandom_range(0, (1 << N) - 1));
      pop = $countones(rm);
      push_op(rm);
      start(rm, rc, 1'b0);
      check_seq($sformatf("rand%0d", r));
      check($sformatf("rand%0d adds", r), o_adds, pop);
      check($sformatf("rand%0d shifts", r), o_shs, N);
      check($sformatf("rand%0d product", r), o_prod, rm * rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
